seq_det_rr_sched: RTL and testbench

// Round-robin scheduler sharing one Mealy serial pattern detector (default 101, overlapping) among N serial sources.

---
 rtl/seq_det_rr_sched.sv | 205 ++++++++++++++++++++
 tb/tb_seq_det_rr_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler that lends one overlapping Mealy pattern detector to N serial sources, one frame at a time.
// Optional stall timeout is enabled by defining SEQ_DET_TIMEOUT_EN.
module seq_det_rr_sched #(
  parameter int               N         = 4,
  parameter int               PAT_W     = 3,
  parameter logic [PAT_W-1:0] PATTERN   = 3'b101,
  parameter int               FRAME_LEN = 8,
  parameter int               CNT_W     = 4,
  parameter int               TIMEOUT   = 16,
  localparam int              IW        = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     bit_in_i,
  input  logic [N-1:0]     bit_vld_i,
  output logic [N-1:0]     grant_o,
  output logic             busy_o,
  output logic             det_out_o,
  output logic             done_o,
  output logic [IW-1:0]    done_ch_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             timeout_o
);

  localparam int BW = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam bit CfgOk = (N >= 2) && (PAT_W >= 2) && (FRAME_LEN >= PAT_W) &&
                         (CNT_W >= 1) && (TIMEOUT >= 1);

  if (!CfgOk) begin : gBadConfig
    $error("seq_det_rr_sched: illegal parameter combination");
  end

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gIdx_q, gIdx_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [BW-1:0]    bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    doneCh_q, doneCh_d;
  logic [CNT_W-1:0] matchCnt_q, matchCnt_d;

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    stall_q, stall_d;
  logic             timeout_q, timeout_d;
`endif

  logic             selFound;
  logic [IW-1:0]    selIdx;
  logic             gReq, gVld, gBit;
  logic             consumed, det, lastBit;
  logic [PAT_W-1:0] window;
  logic [CNT_W-1:0] cntInc;
  logic [IW-1:0]    nextPtr;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int j;
    j        = 0;
    selFound = 1'b0;
    selIdx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!selFound && req_i[j]) begin
        selFound = 1'b1;
        selIdx   = IW'(j);
      end
    end
  end

  assign gReq     = req_i[gIdx_q];
  assign gVld     = bit_vld_i[gIdx_q];
  assign gBit     = bit_in_i[gIdx_q];
  assign window   = {hist_q, gBit};
  assign consumed = (state_q == S_STREAM) && gVld;
  assign det      = consumed && (bitCnt_q >= BW'(PAT_W - 1)) && (window == PATTERN);
  assign lastBit  = consumed && (bitCnt_q == BW'(FRAME_LEN - 1));
  assign cntInc   = (det && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  assign nextPtr  = (gIdx_q == IW'(N - 1)) ? '0 : gIdx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    gIdx_d     = gIdx_q;
    hist_d     = hist_q;
    bitCnt_d   = bitCnt_q;
    cnt_d      = cnt_q;
    doneCh_d   = doneCh_q;
    matchCnt_d = matchCnt_q;
`ifdef SEQ_DET_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        hist_d   = '0;
        bitCnt_d = '0;
        cnt_d    = '0;
`ifdef SEQ_DET_TIMEOUT_EN
        stall_d  = '0;
`endif
        if (selFound) begin
          grant_d         = '0;
          grant_d[selIdx] = 1'b1;
          gIdx_d          = selIdx;
          state_d         = S_STREAM;
        end
      end
      S_STREAM: begin
        // A dropped request aborts the frame even if the last bit arrives in the same cycle.
        if (!gReq) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = nextPtr;
        end else begin
          if (consumed) begin
            hist_d   = window[PAT_W-2:0];
            bitCnt_d = bitCnt_q + 1'b1;
            cnt_d    = cntInc;
          end
          if (lastBit) begin
            state_d    = S_REPORT;
            grant_d    = '0;
            doneCh_d   = gIdx_q;
            matchCnt_d = cntInc;
`ifdef SEQ_DET_TIMEOUT_EN
            timeout_d  = 1'b0;
`endif
          end
`ifdef SEQ_DET_TIMEOUT_EN
          if (consumed) begin
            stall_d = '0;
          end else if (stall_q == TW'(TIMEOUT - 1)) begin
            state_d    = S_REPORT;
            grant_d    = '0;
            doneCh_d   = gIdx_q;
            matchCnt_d = cnt_q;
            timeout_d  = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
`endif
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
        ptr_d   = nextPtr;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      gIdx_q     <= '0;
      hist_q     <= '0;
      bitCnt_q   <= '0;
      cnt_q      <= '0;
      doneCh_q   <= '0;
      matchCnt_q <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
      stall_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      gIdx_q     <= gIdx_d;
      hist_q     <= hist_d;
      bitCnt_q   <= bitCnt_d;
      cnt_q      <= cnt_d;
      doneCh_q   <= doneCh_d;
      matchCnt_q <= matchCnt_d;
`ifdef SEQ_DET_TIMEOUT_EN
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign busy_o      = (state_q == S_STREAM) || (state_q == S_REPORT);
  assign det_out_o   = det;
  assign done_o      = (state_q == S_REPORT);
  assign done_ch_o   = doneCh_q;
  assign match_cnt_o = matchCnt_q;
`ifdef SEQ_DET_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Testbench for seq_det_rr_sched: directed and randomized frames checked against a frame-level reference model.
// A second instance with a narrow counter and longer frame exercises match-count saturation.
module tb_seq_det_rr_sched;

  localparam int N   = 4;
  localparam int PAT_W = 3;
  localparam int FL  = 8;
  localparam int CW  = 4;
  localparam int FL2 = 12;
  localparam int CW2 = 2;
  localparam logic [PAT_W-1:0] PAT = 3'b101;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0, bitIn = '0, bitVld = '0;
  logic [N-1:0]  grant;
  logic          busy, detOut, done, timeoutO;
  logic [1:0]    doneCh;
  logic [CW-1:0] matchCnt;

  logic [N-1:0]   req2 = '0, bitIn2 = '0, bitVld2 = '0;
  logic [N-1:0]   grant2;
  logic           busy2, det2, done2, timeout2;
  logic [1:0]     doneCh2;
  logic [CW2-1:0] matchCnt2;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Reference model state: pointer, last reported result, bits consumed this frame.
  int mPtr = 0;
  int mLastCnt = 0;
  int mLastCh = 0;
  int seenBits[$];

  seq_det_rr_sched dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .bit_in_i(bitIn), .bit_vld_i(bitVld),
    .grant_o(grant), .busy_o(busy), .det_out_o(detOut), .done_o(done),
    .done_ch_o(doneCh), .match_cnt_o(matchCnt), .timeout_o(timeoutO)
  );

  seq_det_rr_sched #(.N(N), .PAT_W(PAT_W), .PATTERN(PAT), .FRAME_LEN(FL2), .CNT_W(CW2)) dutSat (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .bit_in_i(bitIn2), .bit_vld_i(bitVld2),
    .grant_o(grant2), .busy_o(busy2), .det_out_o(det2), .done_o(done2),
    .done_ch_o(doneCh2), .match_cnt_o(matchCnt2), .timeout_o(timeout2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pickGrant(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // True when the most recent PAT_W consumed bits spell the pattern, oldest first.
  function automatic bit tailMatches();
    int v;
    int s;
    v = 0;
    s = seenBits.size();
    if (s < PAT_W) return 1'b0;
    for (int i = s - PAT_W; i < s; i++) v = v * 2 + seenBits[i];
    return v == int'(PAT);
  endfunction

  // One frame: IDLE request cycle, streaming until FRAME_LEN bits or an abort, then the report/abort check.
  // vldMode: 0 = valid every cycle, 1 = valid every other cycle starting low, 2 = random with short gaps.
  task automatic applyStimulus(input logic [N-1:0] reqMask, input logic [FL-1:0] bits,
                               input int vldMode, input int abortAfter);
    int ch, nBits, gapRun, hits, expCnt;
    logic v, aborted, expDet;
    logic [N-1:0] expGrant;
    ch = pickGrant(reqMask, mPtr);
    expGrant = '0;
    expGrant[ch] = 1'b1;
    nBits = 0; gapRun = 0; hits = 0; aborted = 1'b0;
    seenBits.delete();
    @(negedge clk);
    req = reqMask; bitIn = N'($urandom); bitVld = N'($urandom);
    #1;
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleGrant", grant, 0);
    for (int cyc = 0; cyc < 200 && nBits < FL; cyc++) begin
      @(negedge clk);
      req = N'($urandom) | expGrant;
      bitIn = N'($urandom);
      bitVld = N'($urandom);
      if (abortAfter >= 0 && nBits == abortAfter) begin
        req[ch] = 1'b0;
        #1;
        checkOutput("abortGrant", grant, expGrant);
        aborted = 1'b1;
        break;
      end
      case (vldMode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = (gapRun >= 3) || ($urandom_range(0, 2) != 0);
      endcase
      bitVld[ch] = v;
      bitIn[ch] = bits[FL-1-nBits];
      if (v) begin
        seenBits.push_back(int'(bits[FL-1-nBits]));
        nBits++;
        gapRun = 0;
      end else begin
        gapRun++;
      end
      expDet = v && tailMatches();
      if (expDet) hits++;
      #1;
      checkOutput("streamGrant", grant, expGrant);
      checkOutput("streamBusy", busy, 1);
      checkOutput("streamDone", done, 0);
      checkOutput("detOut", detOut, expDet);
    end
    @(negedge clk);
    req = '0; bitVld = '0;
    #1;
    if (aborted) begin
      checkOutput("abortGrantLow", grant, 0);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortNoDone", done, 0);
      checkOutput("abortCntHeld", matchCnt, mLastCnt);
      checkOutput("abortChHeld", doneCh, mLastCh);
    end else begin
      expCnt = (hits > 15) ? 15 : hits;
      checkOutput("reportDone", done, 1);
      checkOutput("reportCh", doneCh, ch);
      checkOutput("reportCnt", matchCnt, expCnt);
      checkOutput("reportGrant", grant, 0);
      checkOutput("reportBusy", busy, 1);
      checkOutput("reportTimeout", timeoutO, 0);
      mLastCnt = expCnt;
      mLastCh = ch;
    end
    mPtr = (ch + 1) % N;
  endtask

  initial begin
    int hits2, dutDets, expSat;
    logic [N-1:0] m;
    logic b;

    #2;
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstDoneCh", doneCh, 0);
    checkOutput("rstMatchCnt", matchCnt, 0);
    checkOutput("rstTimeout", timeoutO, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] round-robin ordering from reset with req=1010");
    applyStimulus(4'b1010, N'($urandom), 2, -1);
    checkOutput("t2First", doneCh, 1);
    applyStimulus(4'b1010, N'($urandom), 2, -1);
    checkOutput("t2Second", doneCh, 3);
    applyStimulus(4'b1010, N'($urandom), 2, -1);
    checkOutput("t2Third", doneCh, 1);

    $display("[TB] directed 10101001 frame, continuous and gapped valid");
    applyStimulus(4'b0001, 8'b10101001, 0, -1);
    checkOutput("t1Count", matchCnt, 2);
    applyStimulus(4'b0001, 8'b10101001, 1, -1);
    checkOutput("t3Count", matchCnt, 2);

    $display("[TB] abort after four bits");
    applyStimulus(4'b0001, 8'b10110101, 0, 4);
    applyStimulus(4'b0101, N'($urandom), 0, -1);
    checkOutput("t4NextCh", doneCh, 2);

    $display("[TB] randomized frames");
    repeat (25) begin
      m = N'($urandom_range(1, 15));
      applyStimulus(m, N'($urandom), 2, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("[TB] asynchronous reset mid-stream");
    @(negedge clk);
    req = 4'b0100; bitVld = '1; bitIn = N'($urandom);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("preRstBusy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncGrant", grant, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncDet", detOut, 0);
    checkOutput("asyncDoneCh", doneCh, 0);
    checkOutput("asyncMatchCnt", matchCnt, 0);
    @(negedge clk);
    req = '0; bitVld = '0;
    rst_n = 1'b1;
    mPtr = 0; mLastCnt = 0; mLastCh = 0;
    applyStimulus(4'b1111, N'($urandom), 0, -1);
    checkOutput("postRstCh", doneCh, 0);

    $display("[TB] match counter saturation, 12-bit frame");
    seenBits.delete();
    hits2 = 0; dutDets = 0;
    @(negedge clk);
    req2 = 4'b0001; bitVld2 = '0;
    #1;
    checkOutput("satIdleGrant", grant2, 0);
    for (int i = 0; i < FL2; i++) begin
      @(negedge clk);
      b = (i % 2 == 0);
      bitIn2 = {3'b000, b};
      bitVld2 = 4'b0001;
      seenBits.push_back(int'(b));
      if (tailMatches()) hits2++;
      #1;
      if (det2 === 1'b1) dutDets++;
      checkOutput("satDet", det2, tailMatches());
    end
    @(negedge clk);
    req2 = '0; bitVld2 = '0;
    #1;
    expSat = (hits2 > 3) ? 3 : hits2;
    checkOutput("satDetTotal", dutDets, hits2);
    checkOutput("satDone", done2, 1);
    checkOutput("satCnt", matchCnt2, expSat);
    checkOutput("satTimeout", timeout2, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
